// File: rtl/dmem_port_if.sv
// One requester's view of the shared data memory: request/beat fields driven
// by the master, grant/ack/read data returned by the arbiter.
interface dmem_port_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, ack, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory with bounded
// bursts; grant/ack/read data are registered, memory pins follow the owner.
module dmem_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   dmem_port_if.slave        m0,
   dmem_port_if.slave        m1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int BEAT_W = $clog2(MAX_BURST) + 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   state_t            state_r, state_nxt_s;
   logic              last_r, last_nxt_s;
   logic [BEAT_W-1:0] beats_r, beats_nxt_s;
   logic              m0_ack_r, m1_ack_r;
   logic [DATA_W-1:0] m0_rdata_r, m1_rdata_r;
   logic              beat0_s, beat1_s;

   assign beat0_s  = (state_r == OWN0) && m0.req;
   assign beat1_s  = (state_r == OWN1) && m1.req;
   assign m0.gnt   = (state_r == OWN0);
   assign m1.gnt   = (state_r == OWN1);
   assign m0.ack   = m0_ack_r;
   assign m1.ack   = m1_ack_r;
   assign m0.rdata = m0_rdata_r;
   assign m1.rdata = m1_rdata_r;

   // Ownership next-state: tie goes to the master that did not own last.
   always_comb begin
      state_nxt_s = state_r;
      last_nxt_s  = last_r;
      beats_nxt_s = beats_r;
      case (state_r)
         IDLE: begin
            if (m0.req && (!m1.req || last_r)) begin
               state_nxt_s = OWN0;
               last_nxt_s  = 1'b0;
               beats_nxt_s = BEAT_ZERO;
            end else if (m1.req) begin
               state_nxt_s = OWN1;
               last_nxt_s  = 1'b1;
               beats_nxt_s = BEAT_ZERO;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         OWN0: begin
            if (!m0.req) begin
               if (m1.req) begin
                  state_nxt_s = OWN1;
                  last_nxt_s  = 1'b1;
                  beats_nxt_s = BEAT_ZERO;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else if (beats_r == BEAT_LAST) begin
               // Burst limit reached: hand over if the other side waits, else restart count.
               beats_nxt_s = BEAT_ZERO;
               if (m1.req) begin
                  state_nxt_s = OWN1;
                  last_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s = OWN0;
               end
            end else begin
               beats_nxt_s = beats_r + BEAT_ONE;
            end
         end
         OWN1: begin
            if (!m1.req) begin
               if (m0.req) begin
                  state_nxt_s = OWN0;
                  last_nxt_s  = 1'b0;
                  beats_nxt_s = BEAT_ZERO;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else if (beats_r == BEAT_LAST) begin
               beats_nxt_s = BEAT_ZERO;
               if (m0.req) begin
                  state_nxt_s = OWN0;
                  last_nxt_s  = 1'b0;
               end else begin
                  state_nxt_s = OWN1;
               end
            end else begin
               beats_nxt_s = beats_r + BEAT_ONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Memory pins steered from the current owner, quiet when idle.
   always_comb begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_write = 1'b0;
      mem_read  = 1'b0;
      case (state_r)
         OWN0: begin
            mem_addr  = m0.addr;
            mem_wdata = m0.wdata;
            mem_write = m0.req & m0.we;
            mem_read  = m0.req & ~m0.we;
         end
         OWN1: begin
            mem_addr  = m1.addr;
            mem_wdata = m1.wdata;
            mem_write = m1.req & m1.we;
            mem_read  = m1.req & ~m1.we;
         end
         default: begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
            mem_write = 1'b0;
            mem_read  = 1'b0;
         end
      endcase
   end

   // State, round-robin pointer, burst count, acks and captured read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         last_r     <= 1'b1;
         beats_r    <= BEAT_ZERO;
         m0_ack_r   <= 1'b0;
         m1_ack_r   <= 1'b0;
         m0_rdata_r <= {DATA_W{1'b0}};
         m1_rdata_r <= {DATA_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         last_r   <= last_nxt_s;
         beats_r  <= beats_nxt_s;
         m0_ack_r <= beat0_s;
         m1_ack_r <= beat1_s;
         if (beat0_s && !m0.we) begin
            m0_rdata_r <= mem_rdata;
         end
         if (beat1_s && !m1.we) begin
            m1_rdata_r <= mem_rdata;
         end
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected acks are queued as beats are
// driven and retired in order as acks appear; each scenario also checks inline.
module tb_dmem_arbiter;
   logic       clk;
   logic       rst;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_write, mem_read;
   logic [7:0] mem_q [256];

   dmem_port_if #(.ADDR_W(8), .DATA_W(8)) p0 ();
   dmem_port_if #(.ADDR_W(8), .DATA_W(8)) p1 ();

   dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .m0(p0), .m1(p1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_read(mem_read), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic       who;
      logic       rd;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rd_cnt = 0;
   int   wr_cnt = 0;
   logic [7:0] last_wr_addr = 8'h00;

   function automatic logic [7:0] pat(input logic [7:0] a);
      return a ^ 8'hB5;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Data memory model: preset pattern on reset, written by the arbiter.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem_q[i] <= pat(8'(i));
      end else if (mem_write) begin
         mem_q[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_q[mem_addr];

   // One clock: tally strobes before the edge, then retire any acks against the scoreboard.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      rd_cnt += int'(mem_read);
      wr_cnt += int'(mem_write);
      if (mem_write) last_wr_addr = mem_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (p0.ack) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_m0_unexpected: m0 ack at cycle %0d, expected none", cyc);
         end else begin
            e = sb_q.pop_front();
            if (e.who !== 1'b0 || (e.rd && p0.rdata !== e.data)) begin
               errors++;
               $display("FAIL sb_m0: got m0 ack rdata=%h, expected master %0d rdata=%h (cycle %0d)",
                        p0.rdata, e.who, e.data, cyc);
            end
         end
      end
      if (p1.ack) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_m1_unexpected: m1 ack at cycle %0d, expected none", cyc);
         end else begin
            e = sb_q.pop_front();
            if (e.who !== 1'b1 || (e.rd && p1.rdata !== e.data)) begin
               errors++;
               $display("FAIL sb_m1: got m1 ack rdata=%h, expected master %0d rdata=%h (cycle %0d)",
                        p1.rdata, e.who, e.data, cyc);
            end
         end
      end
   endtask

   task automatic test_reset();
      p0.req = 1'b0; p0.we = 1'b0; p0.addr = 8'h00; p0.wdata = 8'h00;
      p1.req = 1'b0; p1.we = 1'b0; p1.addr = 8'h00; p1.wdata = 8'h00;
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({p0.gnt, p1.gnt, p0.ack, p1.ack, mem_write, mem_read} !== 6'b000000 ||
          p0.rdata !== 8'h00 || p1.rdata !== 8'h00 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: gnt=%b%b ack=%b%b wr=%b rd=%b rdata=%h/%h addr=%h wdata=%h, expected all 0",
                  p0.gnt, p1.gnt, p0.ack, p1.ack, mem_write, mem_read, p0.rdata, p1.rdata, mem_addr, mem_wdata);
      end
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      int rd0 = rd_cnt;
      p0.req = 1'b1; p0.we = 1'b0; p0.addr = 8'h10;
      sb_q.push_back('{who: 1'b0, rd: 1'b1, data: 8'hA5});
      tick();
      checks++;
      if (p0.gnt !== 1'b1 || p0.ack !== 1'b0) begin
         errors++;
         $display("FAIL single_gnt: gnt=%b ack=%b, expected gnt=1 ack=0", p0.gnt, p0.ack);
      end
      tick();
      checks++;
      if (p0.ack !== 1'b1 || p0.rdata !== 8'hA5) begin
         errors++;
         $display("FAIL single_ack: ack=%b rdata=%h, expected ack=1 rdata=a5", p0.ack, p0.rdata);
      end
      p0.req = 1'b0;
      tick();
      checks++;
      if (p0.ack !== 1'b0 || rd_cnt - rd0 != 1) begin
         errors++;
         $display("FAIL single_strobe: ack=%b read_cycles=%0d, expected ack=0 read_cycles=1", p0.ack, rd_cnt - rd0);
      end
      tick();
   endtask

   task automatic test_write_readback();
      int wr0 = wr_cnt;
      p1.req = 1'b1; p1.we = 1'b1; p1.addr = 8'h20; p1.wdata = 8'h3C;
      sb_q.push_back('{who: 1'b1, rd: 1'b0, data: 8'h00});
      tick();
      checks++;
      if (p1.gnt !== 1'b1) begin
         errors++;
         $display("FAIL wr_gnt: m1 gnt=%b, expected 1", p1.gnt);
      end
      tick();
      p1.req = 1'b0;
      tick();
      checks++;
      if (wr_cnt - wr0 != 1 || last_wr_addr !== 8'h20) begin
         errors++;
         $display("FAIL wr_strobe: write_cycles=%0d addr=%h, expected 1 cycle at addr 20", wr_cnt - wr0, last_wr_addr);
      end
      p0.req = 1'b1; p0.we = 1'b0; p0.addr = 8'h20;
      sb_q.push_back('{who: 1'b0, rd: 1'b1, data: 8'h3C});
      tick();
      tick();
      checks++;
      if (p0.ack !== 1'b1 || p0.rdata !== 8'h3C) begin
         errors++;
         $display("FAIL readback: ack=%b rdata=%h, expected ack=1 rdata=3c", p0.ack, p0.rdata);
      end
      p0.req = 1'b0;
      tick();
   endtask

   task automatic test_tie_after_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      p0.req = 1'b1; p0.we = 1'b0; p0.addr = 8'h01;
      p1.req = 1'b1; p1.we = 1'b0; p1.addr = 8'h02;
      sb_q.push_back('{who: 1'b0, rd: 1'b1, data: pat(8'h01)});
      sb_q.push_back('{who: 1'b1, rd: 1'b1, data: pat(8'h02)});
      tick();
      checks++;
      if (p0.gnt !== 1'b1 || p1.gnt !== 1'b0) begin
         errors++;
         $display("FAIL tie_first: gnt0=%b gnt1=%b, expected 1/0", p0.gnt, p1.gnt);
      end
      tick();
      p0.req = 1'b0;
      tick();
      checks++;
      if (p0.gnt !== 1'b0 || p1.gnt !== 1'b1) begin
         errors++;
         $display("FAIL tie_handover: gnt0=%b gnt1=%b, expected 0/1 with no idle", p0.gnt, p1.gnt);
      end
      tick();
      p1.req = 1'b0;
      tick();
      checks++;
      if (p0.gnt !== 1'b0 || p1.gnt !== 1'b0 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL tie_end: gnt=%b%b pending=%0d, expected idle and 0 pending", p0.gnt, p1.gnt, sb_q.size());
      end
   endtask

   task automatic test_preemption();
      int exp_pat [20] = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 0};
      int cnt0 = 0;
      int cnt1 = 0;
      int obs;
      for (int i = 0; i < 20; i++) begin
         if (exp_pat[i] == 1) sb_q.push_back('{who: 1'b0, rd: 1'b1, data: pat(8'h30)});
         if (exp_pat[i] == 2) sb_q.push_back('{who: 1'b1, rd: 1'b1, data: pat(8'h41)});
      end
      p0.req = 1'b1; p0.we = 1'b0; p0.addr = 8'h30;
      p1.we = 1'b0; p1.addr = 8'h41;
      for (int i = 0; i < 20; i++) begin
         tick();
         obs = p0.ack ? 1 : (p1.ack ? 2 : 0);
         checks++;
         if (obs != exp_pat[i]) begin
            errors++;
            $display("FAIL preempt_seq[%0d]: ack owner=%0d, expected %0d", i, obs, exp_pat[i]);
         end
         if (i == 4) begin
            checks++;
            if (p1.gnt !== 1'b1 || p0.gnt !== 1'b0) begin
               errors++;
               $display("FAIL preempt_gnt: gnt0=%b gnt1=%b after 4th m0 beat, expected 0/1", p0.gnt, p1.gnt);
            end
         end
         if (p0.ack) cnt0++;
         if (p1.ack) cnt1++;
         if (cnt0 == 1) p1.req = 1'b1;
         if (cnt0 == 10) p0.req = 1'b0;
         if (cnt1 == 8) p1.req = 1'b0;
      end
   endtask

   task automatic test_solo_burst();
      p0.req = 1'b1; p0.we = 1'b0; p0.addr = 8'h50;
      for (int j = 0; j < 9; j++) sb_q.push_back('{who: 1'b0, rd: 1'b1, data: pat(8'(8'h50 + j))});
      tick();
      for (int j = 0; j < 9; j++) begin
         tick();
         checks++;
         if (p0.gnt !== 1'b1 || p0.ack !== 1'b1 || p0.rdata !== pat(8'(8'h50 + j))) begin
            errors++;
            $display("FAIL solo_beat[%0d]: gnt=%b ack=%b rdata=%h, expected 1/1/%h",
                     j, p0.gnt, p0.ack, p0.rdata, pat(8'(8'h50 + j)));
         end
         p0.addr = 8'(8'h51 + j);
         if (j == 8) p0.req = 1'b0;
      end
      tick();
      checks++;
      if (p0.gnt !== 1'b0 || p0.ack !== 1'b0) begin
         errors++;
         $display("FAIL solo_end: gnt=%b ack=%b, expected 0/0", p0.gnt, p0.ack);
      end
   endtask

   task automatic test_reset_mid_burst();
      p0.req = 1'b1; p0.we = 1'b1; p0.addr = 8'h60; p0.wdata = 8'hC0;
      sb_q.push_back('{who: 1'b0, rd: 1'b0, data: 8'h00});
      sb_q.push_back('{who: 1'b0, rd: 1'b0, data: 8'h00});
      tick();
      tick();
      p0.addr = 8'h61; p0.wdata = 8'hC1;
      tick();
      p0.addr = 8'h62; p0.wdata = 8'hC2;
      checks++;
      if (p0.ack !== 1'b1 || mem_write !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: ack=%b mem_write=%b, expected 1/1 before reset", p0.ack, mem_write);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_write !== 1'b0 || p0.gnt !== 1'b0 || p0.ack !== 1'b0 || mem_addr !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid: mem_write=%b gnt=%b ack=%b addr=%h, expected all 0",
                  mem_write, p0.gnt, p0.ack, mem_addr);
      end
      p0.req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      p0.req = 1'b1; p0.we = 1'b0; p0.addr = 8'h70;
      p1.req = 1'b1; p1.we = 1'b0; p1.addr = 8'h71;
      sb_q.push_back('{who: 1'b0, rd: 1'b1, data: pat(8'h70)});
      sb_q.push_back('{who: 1'b1, rd: 1'b1, data: pat(8'h71)});
      tick();
      checks++;
      if (p0.gnt !== 1'b1 || p1.gnt !== 1'b0) begin
         errors++;
         $display("FAIL rst_tie: gnt0=%b gnt1=%b, expected 1/0", p0.gnt, p1.gnt);
      end
      tick();
      p0.req = 1'b0;
      tick();
      tick();
      p1.req = 1'b0;
      tick();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d acks still pending, expected 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_readback();
      test_tie_after_reset();
      test_preemption();
      test_solo_burst();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
